// File: rtl/adc_acq_pkg.sv
// Shared types for the ADC acquisition scheduler: FSM state encoding and next-channel search.
// Pure declarations; no latency or backpressure of its own.
package adc_acq_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CONVERT,
        OUTPUT
    } state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } ch_search_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lowest set bit of mask at index >= from; found=0 when none remains.
    function automatic ch_search_t next_set_ch(input logic [MAX_CH-1:0] mask, input int from);
        ch_search_t res;
        res = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                res.found = 1'b1;
                res.idx   = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adc_acq_scheduler_if.sv
// ADC control lines plus the captured-sample valid/ready stream.
// Master is the scheduler; slave is the ADC front end and downstream consumer.
interface adc_acq_scheduler_if #(
    parameter int CH_W   = 3,
    parameter int DATA_W = 32
);

    logic [CH_W-1:0]   adc_ch_sel;
    logic              adc_conv_start;
    logic              adc_conv_done;
    logic [DATA_W-1:0] adc_data;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CH_W-1:0]   m_ch;
    logic              m_last;

    modport master (
        output adc_ch_sel,
        output adc_conv_start,
        input  adc_conv_done,
        input  adc_data,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_ch,
        output m_last
    );

    modport slave (
        input  adc_ch_sel,
        input  adc_conv_start,
        output adc_conv_done,
        output adc_data,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_ch,
        input  m_last
    );

endinterface

// File: rtl/adc_tick_gen.sv
// Enable-gated period counter emitting a one-cycle tick every TICK_DIV cycles.
// Tick is combinational from the count; counter is held at zero while disabled.
module adc_tick_gen #(
    parameter int TICK_DIV = 390625
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/adc_acq_scheduler.sv
// Scans masked ADC channels once per tick: select, settle, convert, emit one word per channel.
// Done at D gives m_valid at D+1; m_ready low holds the word and stalls the scan.
module adc_acq_scheduler
    import adc_acq_pkg::*;
#(
    parameter int CLK_FREQ      = 100000000,
    parameter int TARGET_FREQ   = 256,
    parameter int NUM_CH        = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int CONV_TIMEOUT  = 1024,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              clear_err,
    adc_acq_scheduler_if.master bus,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int TICK_DIV = CLK_FREQ / TARGET_FREQ;
    localparam int CH_W     = ch_width(NUM_CH);
    localparam int CNT_MAX  = (SETTLE_CYCLES > CONV_TIMEOUT) ? SETTLE_CYCLES : CONV_TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CONV_TIMEOUT - 1);

    logic tick;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic              start_q, start_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CH_W-1:0]   m_ch_q, m_ch_d;
    logic              m_last_q, m_last_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    ch_search_t first_ch;
    ch_search_t next_ch;
    logic       conv_ok;
    logic       timeout_hit;

    adc_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (enable),
        .tick_o (tick)
    );

    assign first_ch = next_set_ch(MAX_CH'(ch_mask), 0);
    assign next_ch  = next_set_ch(MAX_CH'(mask_q), int'(ch_sel_q) + 1);

    // Done is not trusted in the start-pulse cycle; it may be left over from the previous channel.
    assign conv_ok  = !start_q && bus.adc_conv_done;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        ch_sel_d    = ch_sel_q;
        start_d     = 1'b0;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_ch_d      = m_ch_q;
        m_last_d    = m_last_q;
        timeout_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && first_ch.found) begin
                    mask_d   = ch_mask;
                    ch_sel_d = CH_W'(first_ch.idx);
                    cnt_d    = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    start_d = 1'b1;
                    state_d = CONVERT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CONVERT: begin
                if (conv_ok || (cnt_q == TIMEOUT_LAST)) begin
                    m_valid_d   = 1'b1;
                    m_data_d    = conv_ok ? bus.adc_data : '0;
                    m_ch_d      = ch_sel_q;
                    m_last_d    = !next_ch.found;
                    timeout_hit = !conv_ok;
                    state_d     = OUTPUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUTPUT: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    if (next_ch.found) begin
                        ch_sel_d = CH_W'(next_ch.idx);
                        cnt_d    = '0;
                        state_d  = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        // A set event in the same cycle as clear_err keeps the flag raised.
        overrun_d = overrun_q;
        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (clear_err) begin
            overrun_d = 1'b0;
        end

        timeout_d = timeout_q;
        if (timeout_hit) begin
            timeout_d = 1'b1;
        end else if (clear_err) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            cnt_q     <= '0;
            ch_sel_q  <= '0;
            start_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            ch_sel_q  <= ch_sel_d;
            start_q   <= start_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ch_q    <= m_ch_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.adc_ch_sel     = ch_sel_q;
    assign bus.adc_conv_start = start_q;
    assign bus.m_valid        = m_valid_q;
    assign bus.m_data         = m_data_q;
    assign bus.m_ch           = m_ch_q;
    assign bus.m_last         = m_last_q;
    assign busy               = busy_q;
    assign overrun            = overrun_q;
    assign timeout_err        = timeout_q;

endmodule

// File: tb/tb_adc_acq_scheduler.sv
// Directed bench for adc_acq_scheduler: ADC responder model, stream scoreboard, timing monitors.
module tb_adc_acq_scheduler;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int DATA_W  = 32;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 8;
    localparam int PERIOD  = 100;
    localparam int ADC_LAT = 3;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NUM_CH-1:0] ch_mask;
    logic              clear_err;
    logic              busy;
    logic              overrun;
    logic              timeout_err;
    logic [NUM_CH-1:0] dead = '0;

    adc_acq_scheduler_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus ();

    adc_acq_scheduler #(
        .CLK_FREQ      (1000),
        .TARGET_FREQ   (10),
        .NUM_CH        (NUM_CH),
        .SETTLE_CYCLES (SETTLE),
        .CONV_TIMEOUT  (TIMEOUT),
        .DATA_W        (DATA_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .clear_err   (clear_err),
        .bus         (bus),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC responder: done pulses ADC_LAT cycles after the start pulse unless the channel is dead.
    int              adc_cnt = 0;
    logic [CH_W-1:0] adc_ch  = '0;
    always @(negedge clk) begin
        bus.adc_conv_done = 1'b0;
        bus.adc_data      = 32'h0BAD_0BAD;
        if (adc_cnt != 0) begin
            adc_cnt = adc_cnt - 1;
            if (adc_cnt == 0) begin
                bus.adc_conv_done = 1'b1;
                bus.adc_data      = 32'hA000_0000 | 32'(adc_ch);
            end
        end
        if (bus.adc_conv_start && !dead[bus.adc_ch_sel]) begin
            adc_cnt = ADC_LAT;
            adc_ch  = bus.adc_ch_sel;
        end
    end

    // Monitor state
    int                conv_cnt = 0, n_frames = 0, n_words = 0;
    int                mark = 0, start_cyc = 0, frame_start = 0, prev_frame_start = 0;
    int                lat [NUM_CH];
    logic              prev_stall = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0;
    logic [CH_W-1:0]   prev_sel = '0, hold_ch = '0, hold_sel = '0;
    logic [DATA_W-1:0] hold_data = '0;
    logic              hold_last = 1'b0;
    exp_t              got;

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if ((bus.adc_ch_sel != prev_sel) || (busy && !prev_busy)) mark = cyc;
            if (busy && !prev_busy) begin
                prev_frame_start = frame_start;
                frame_start      = cyc;
                n_frames++;
            end
            if (bus.adc_conv_start) begin
                conv_cnt++;
                start_cyc = cyc;
                check("settle_to_start", cyc - mark, SETTLE);
            end
            if (bus.m_valid && !prev_valid) lat[bus.m_ch] = cyc - start_cyc;
            if (prev_stall) begin
                check("stall_valid", bus.m_valid, 1'b1);
                check("stall_data", bus.m_data, hold_data);
                check("stall_ch", bus.m_ch, hold_ch);
                check("stall_last", bus.m_last, hold_last);
                check("stall_sel", bus.adc_ch_sel, hold_sel);
                check("stall_no_start", bus.adc_conv_start, 1'b0);
            end
            if (bus.m_valid && bus.m_ready) begin
                n_words++;
                check("word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("word_ch", bus.m_ch, got.ch);
                    check("word_data", bus.m_data, got.data);
                    check("word_last", bus.m_last, got.last);
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            hold_data  = bus.m_data;
            hold_ch    = bus.m_ch;
            hold_last  = bus.m_last;
            hold_sel   = bus.adc_ch_sel;
        end else begin
            prev_stall = 1'b0;
        end
        prev_sel   = bus.adc_ch_sel;
        prev_busy  = busy;
        prev_valid = bus.m_valid;
    end

    task automatic push_frame(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] dd);
        int   top_ch;
        exp_t e;
        top_ch = -1;
        for (int i = 0; i < NUM_CH; i++) if (mask[i]) top_ch = i;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
                e.ch   = CH_W'(i);
                e.data = dd[i] ? '0 : (32'hA000_0000 | 32'(i));
                e.last = (i == top_ch);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!bus.m_valid && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", bus.m_valid, 1'b1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_reset();
        check("rst_ch_sel", bus.adc_ch_sel, 0);
        check("rst_conv_start", bus.adc_conv_start, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_ch", bus.m_ch, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout_err", timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cyc, c0, f0, w0, b, n;

        rst_n       = 1'b0;
        enable      = 1'b0;
        ch_mask     = '0;
        clear_err   = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frames: tick phase, per-channel timing, frame spacing, pulse count
        ch_mask = 4'b1011;
        push_frame(4'b1011, '0);
        c0      = conv_cnt;
        en_cyc  = cyc;
        enable  = 1'b1;
        wait_drain(300);
        check("first_frame_start", frame_start, en_cyc + PERIOD);
        check("lat_ch0", lat[0], ADC_LAT + 1);
        check("lat_ch3", lat[3], ADC_LAT + 1);
        push_frame(4'b1011, '0);
        wait_drain(300);
        check("frame_spacing", frame_start - prev_frame_start, PERIOD);
        check("conv_two_frames", conv_cnt - c0, 6);

        // Backpressure on the first word of a frame
        push_frame(4'b1011, '0);
        c0 = conv_cnt;
        wait_valid(300);
        bus.m_ready = 1'b0;
        repeat (20) @(negedge clk);
        bus.m_ready = 1'b1;
        wait_drain(300);
        check("stall_frame_conv", conv_cnt - c0, 3);

        // Conversion timeout on channel 1
        dead = 4'b0010;
        push_frame(4'b1011, dead);
        wait_drain(300);
        check("timeout_lat_ch1", lat[1], TIMEOUT);
        check("timeout_lat_ch3", lat[3], ADC_LAT + 1);
        check("timeout_err_set", timeout_err, 1'b1);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        #1;
        check("timeout_err_clr", timeout_err, 1'b0);
        dead = '0;

        // Overrun: stall across two ticks, clear_err colliding with the second
        f0 = n_frames;
        push_frame(4'b1011, '0);
        wait_valid(300);
        b = frame_start;
        bus.m_ready = 1'b0;
        wait_cyc(b + PERIOD + 2);
        check("overrun_set", overrun, 1'b1);
        wait_cyc(b + 2 * PERIOD - 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        #1;
        check("overrun_set_wins", overrun, 1'b1);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        #1;
        check("overrun_clr", overrun, 1'b0);
        bus.m_ready = 1'b1;
        wait_drain(300);
        check("one_frame_two_periods", n_frames - f0, 1);

        // Empty mask: ticks ignored entirely
        ch_mask = '0;
        c0      = conv_cnt;
        f0      = n_frames;
        wait_cyc(b + 4 * PERIOD + 5);
        check("mask0_conv", conv_cnt - c0, 0);
        check("mask0_frames", n_frames - f0, 0);
        check("mask0_busy", busy, 1'b0);
        check("mask0_overrun", overrun, 1'b0);

        // Enable dropped mid-frame: frame completes, nothing after
        ch_mask = 4'b1011;
        push_frame(4'b1011, '0);
        c0 = conv_cnt;
        f0 = n_frames;
        n  = 0;
        while ((n_frames == f0) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        check("enable_frame_started", n_frames - f0, 1);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        wait_drain(300);
        check("enable_drop_conv", conv_cnt - c0, 3);
        repeat (250) @(negedge clk);
        check("enable_off_conv", conv_cnt - c0, 3);
        check("enable_off_frames", n_frames - f0, 1);

        // Reset in the middle of a conversion
        enable = 1'b1;
        c0     = conv_cnt;
        w0     = n_words;
        n      = 0;
        while ((conv_cnt == c0) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        check("rst_saw_start", conv_cnt - c0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset();
        repeat (50) @(negedge clk);
        check("no_stale_valid", n_words - w0, 0);
        push_frame(4'b1011, '0);
        wait_drain(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_acq_scheduler.md
# adc_acq_scheduler

Multi-channel acquisition scheduler that sequences a single shared ADC across up to NUM_CH EEG electrode channels. Once per sampling period it scans a masked set of channels: it selects each channel, waits for the mux to settle, starts a conversion, and captures the result. Each captured word goes out on a valid/ready stream to the downstream filtering pipeline. It replaces the free-running sampler as the sole owner of the sampling tick and the ADC control lines.

## Interface
- CLK_FREQ, 100000000, input clock frequency (Hz)
- TARGET_FREQ, 256, frame (scan) rate (Hz); TICK_DIV = CLK_FREQ / TARGET_FREQ
- NUM_CH, 8, number of ADC channels (1..16); CH_W = max(1, $clog2(NUM_CH))
- SETTLE_CYCLES, 16, mux settle time in clk cycles (>= 1)
- CONV_TIMEOUT, 1024, max cycles to wait for adc_conv_done (>= 2)
- DATA_W, 32, sample width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  allow new scans
- ch_mask  in  NUM_CH  channels to scan; latched at scan start
- clear_err  in  1  clears sticky error flags
- adc_ch_sel  out  CH_W  ADC mux channel select
- adc_conv_start  out  1  one-cycle conversion start pulse
- adc_conv_done  in  1  conversion complete, qualifies adc_data
- adc_data  in  DATA_W  conversion result
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  sample
- m_ch  out  CH_W  channel index of m_data
- m_last  out  1  last word of the frame
- busy  out  1  scan in progress (state != IDLE)
- overrun  out  1  sticky: tick arrived while busy
- timeout_err  out  1  sticky: a conversion timed out

## Operation
- Tick counter: runs 0..TICK_DIV-1 while enable=1. `tick` pulses for one cycle at TICK_DIV-1, then the counter wraps to 0. While enable=0 the counter is held at 0.
- FSM states: IDLE, SETTLE, CONVERT, OUTPUT.
- IDLE: when tick=1 and ch_mask != 0:
  - latch the mask.
  - load adc_ch_sel with the lowest set channel.
  - go to SETTLE.
  - A tick with ch_mask=0 is ignored and does not set overrun.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then goes to CONVERT.
- CONVERT:
  - adc_conv_start is high in the first CONVERT cycle only.
  - adc_conv_done is ignored in that cycle; it is sampled from the next cycle on.
  - On adc_conv_done=1: register m_data=adc_data, m_ch=adc_ch_sel, m_last=(no higher set bit in the latched mask); go to OUTPUT.
  - If CONV_TIMEOUT cycles pass after the start pulse without done: emit m_data=0 with the same m_ch/m_last rules, set timeout_err, and go to OUTPUT.
- OUTPUT:
  - m_valid=1; m_data, m_ch and m_last are held stable until m_valid && m_ready.
  - On handshake, if channels remain: move adc_ch_sel to the next higher set channel and go to SETTLE.
  - Otherwise go to IDLE.
- Overrun: a tick while state != IDLE sets overrun. That tick is dropped and not queued.
- enable deasserted mid-scan: the current frame completes, including the pending output word. No new scan starts.
- clear_err clears overrun and timeout_err. If a set event and clear_err occur in the same cycle, set wins.
- adc_ch_sel holds its value in IDLE.

## Timing
- Reset values (rst_n=0 at a clk edge):
  - state IDLE
  - tick counter 0
  - adc_ch_sel 0, adc_conv_start 0
  - m_valid 0, m_data 0, m_ch 0, m_last 0
  - busy 0, overrun 0, timeout_err 0
- Reset mid-operation discards the in-flight word. No stale m_valid appears after release.
- Tick at cycle T gives: SETTLE and new adc_ch_sel at T+1; adc_conv_start at T+1+SETTLE_CYCLES.
- adc_conv_done seen at cycle D gives m_valid=1 at D+1.
- A handshake at cycle H gives the next channel's adc_ch_sel at H+1.
- Per-channel cost with m_ready=1: SETTLE_CYCLES + conversion latency + 2 cycles.
- TICK_DIV must exceed the worst-case frame time. If it does not, overrun reports it; it is not a hard error.
- All outputs are registered.

## Structure
- Package adc_acq_pkg: state enum (IDLE, SETTLE, CONVERT, OUTPUT) and a lowest-set-bit-at-or-above-index function for next-channel search.
- Sub-module adc_tick_gen: the enable-gated TICK_DIV counter emitting a one-cycle tick. It is reusable by other periodic blocks.
- Top level: FSM, settle/timeout counter (shared, width $clog2(max(SETTLE_CYCLES, CONV_TIMEOUT))+1), output register, error flags.

## Test plan
- Basic frame. Setup: NUM_CH=4, CLK_FREQ=1000, TARGET_FREQ=10, SETTLE_CYCLES=4, mask 4'b1011; ADC model asserts done 3 cycles after start with data 32'hA000_000<ch>. Required: words (ch0,A0000000), (ch1,A0000001), (ch3,A0000003); m_last only on ch3; exactly 3 conv_start pulses per frame, each 4 cycles after the adc_ch_sel change; frames 100 cycles apart.
- Backpressure: m_ready=0 for 20 cycles during OUTPUT. Required: m_valid, m_data, m_ch stable; adc_ch_sel unchanged; no conv_start; the frame resumes in order after m_ready=1.
- Timeout: the ADC never raises done on ch1, CONV_TIMEOUT=8. Required: a (ch1, 0) word 8 cycles after start; timeout_err=1; ch3 still converted; clear_err returns timeout_err to 0 next cycle.
- Overrun: hold m_ready=0 past the next tick. Required: overrun=1; one frame emitted for the two periods; with clear_err and a new overrun tick in the same cycle, overrun stays 1.
- Mask and enable: ch_mask=0 gives no conv_start, busy=0, overrun=0. Dropping enable mid-frame completes the frame, then no further conv_start.
- Reset mid-CONVERT: rst_n=0 for one cycle. Required: all outputs at reset values next cycle; no m_valid until a new tick and full scan.
